// File: rtl/mb_point_test_pattern_gen.sv
// Mainband / valid-lane test pattern generator fed by the D2C point-test controller.
// Optional first-UI error injection is enabled by defining PATTERN_GEN_ERR_INJECT_EN.
module mb_ptg_lane #(
  parameter int          LANE = 0,
  parameter logic [22:0] SEED = 23'h1DBFBC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reseed_i,
  input  logic       adv_i,
  input  logic       id_mode_i,
  input  logic [3:0] phase_i,
  output logic       bit_o
);
  localparam logic [7:0]  LID     = 8'(LANE);
  localparam logic [15:0] ID_WORD = {4'b1010, LID, 4'b1010};

  logic [22:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (reseed_i)
      lfsr_d = SEED;
    else if (adv_i)
      lfsr_d = {lfsr_q[21:0],
                lfsr_q[22] ^ lfsr_q[20] ^ lfsr_q[17] ^ lfsr_q[14] ^ lfsr_q[6] ^ lfsr_q[1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign bit_o = id_mode_i ? ID_WORD[phase_i] : lfsr_q[22];
endmodule

module mb_point_test_pattern_gen #(
  parameter int          NUM_LANES  = 16,
  parameter int          PATTERN_UI = 4096,
  parameter logic [22:0] SEED_BASE  = 23'h1DBFBC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           i_mainband_pattern_generator_cw,
  input  logic                 i_val_pattern_en,
`ifdef PATTERN_GEN_ERR_INJECT_EN
  input  logic [NUM_LANES-1:0] i_err_inject_lanes,
`endif
  output logic [NUM_LANES-1:0] o_lane_data,
  output logic                 o_valid_lane,
  output logic                 o_data_en,
  output logic                 o_pattern_finished
);
  localparam int CNT_W = $clog2(PATTERN_UI + 1);

  typedef enum logic [2:0] {IDLE, RUN_LFSR, RUN_ID, RUN_VAL, DONE} st_e;

  st_e                  st_q, st_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 src_val_q, src_val_d;
  logic [NUM_LANES-1:0] inj_q, inj_d, err_sel, lane_bits;
  logic [NUM_LANES-1:0] lane_q, lane_d;
  logic                 valid_q, valid_d, den_q, den_d, fin_q, fin_d;
  logic                 held, last, reseed, adv;

`ifdef PATTERN_GEN_ERR_INJECT_EN
  assign err_sel = i_err_inject_lanes;
`else
  assign err_sel = '0;
`endif

  // The request that launched the current run must stay asserted unchanged.
  always_comb begin
    held = 1'b0;
    case (st_q)
      RUN_LFSR: held = (i_mainband_pattern_generator_cw == 2'b10);
      RUN_ID:   held = (i_mainband_pattern_generator_cw == 2'b11);
      RUN_VAL:  held = (i_mainband_pattern_generator_cw == 2'b00) && i_val_pattern_en;
      default:  held = 1'b0;
    endcase
  end

  assign last   = (cnt_q == CNT_W'(PATTERN_UI - 1));
  assign reseed = (st_q == IDLE) && (i_mainband_pattern_generator_cw == 2'b01);
  assign adv    = (st_q == RUN_LFSR) && held;

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      localparam logic [22:0] S    = SEED_BASE ^ (23'(k) << 4);
      localparam logic [22:0] SEED = (S == '0) ? SEED_BASE : S;
      mb_ptg_lane #(.LANE(k), .SEED(SEED)) u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .reseed_i  (reseed),
        .adv_i     (adv),
        .id_mode_i (st_q == RUN_ID),
        .phase_i   (cnt_q[3:0]),
        .bit_o     (lane_bits[k])
      );
    end
  endgenerate

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    src_val_d = src_val_q;
    inj_d     = inj_q;
    lane_d    = '0;
    valid_d   = 1'b0;
    den_d     = 1'b0;
    fin_d     = 1'b0;
    unique case (st_q)
      IDLE: begin
        cnt_d = '0;
        if (i_mainband_pattern_generator_cw == 2'b10) begin
          st_d = RUN_LFSR; src_val_d = 1'b0; inj_d = err_sel;
        end else if (i_mainband_pattern_generator_cw == 2'b11) begin
          st_d = RUN_ID; src_val_d = 1'b0; inj_d = err_sel;
        end else if (i_mainband_pattern_generator_cw == 2'b00 && i_val_pattern_en) begin
          st_d = RUN_VAL; src_val_d = 1'b1; inj_d = '0;
        end
      end
      RUN_LFSR, RUN_ID, RUN_VAL: begin
        if (!held) begin
          st_d = IDLE;
        end else begin
          den_d   = 1'b1;
          valid_d = ~cnt_q[2];
          // Injection flips only the first UI; the LFSR itself is untouched.
          lane_d  = (st_q == RUN_VAL) ? '0 :
                    (lane_bits ^ ((cnt_q == '0) ? inj_q : '0));
          cnt_d   = cnt_q + CNT_W'(1);
          if (last) st_d = DONE;
        end
      end
      DONE: begin
        if (src_val_q ? !i_val_pattern_en : (i_mainband_pattern_generator_cw == 2'b00))
          st_d = IDLE;
        else
          fin_d = 1'b1;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      cnt_q     <= '0;
      src_val_q <= 1'b0;
      inj_q     <= '0;
      lane_q    <= '0;
      valid_q   <= 1'b0;
      den_q     <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      src_val_q <= src_val_d;
      inj_q     <= inj_d;
      lane_q    <= lane_d;
      valid_q   <= valid_d;
      den_q     <= den_d;
      fin_q     <= fin_d;
    end
  end

  assign o_lane_data        = lane_q;
  assign o_valid_lane       = valid_q;
  assign o_data_en          = den_q;
  assign o_pattern_finished = fin_q;
endmodule

// File: tb/tb_mb_point_test_pattern_gen.sv
// Bench for mb_point_test_pattern_gen: LFSR reference built from the output-stream recurrence.
module tb_mb_point_test_pattern_gen;
  localparam int          NL    = 16;
  localparam int          PUI   = 4096;
  localparam int          DEPTH = 16384;
  localparam logic [22:0] SB    = 23'h1DBFBC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    cw = 2'b00;
  logic          val_en = 1'b0;
  logic [NL-1:0] lane;
  logic          valid, den, fin;
  logic [NL-1:0] err_lanes = '0;

  int n_chk = 0;
  int n_pass = 0;
  bit strm [NL][DEPTH];
  int pos = 0;

  always #5 clk = ~clk;

  mb_point_test_pattern_gen #(.NUM_LANES(NL), .PATTERN_UI(PUI), .SEED_BASE(SB)) dut (
    .clk                             (clk),
    .rst_n                           (rst_n),
    .i_mainband_pattern_generator_cw (cw),
    .i_val_pattern_en                (val_en),
`ifdef PATTERN_GEN_ERR_INJECT_EN
    .i_err_inject_lanes              (err_lanes),
`endif
    .o_lane_data                     (lane),
    .o_valid_lane                    (valid),
    .o_data_en                       (den),
    .o_pattern_finished              (fin)
  );

  // Output stream o[n] of the Fibonacci LFSR obeys o[n+23] = o[n]^o[n+2]^o[n+5]^o[n+8]^o[n+16]^o[n+21].
  function automatic void build_model();
    for (int k = 0; k < NL; k++) begin
      logic [22:0] s;
      s = SB ^ (23'(k) << 4);
      for (int i = 0; i < 23; i++) strm[k][i] = s[22-i];
      for (int n = 0; n + 23 < DEPTH; n++)
        strm[k][n+23] = strm[k][n] ^ strm[k][n+2] ^ strm[k][n+5] ^ strm[k][n+8]
                      ^ strm[k][n+16] ^ strm[k][n+21];
    end
  endfunction

  // mode 0: LFSR, 1: lane ID, 2: valtrain
  function automatic logic [NL-1:0] exp_lanes(input int mode, input int ui);
    logic [NL-1:0] v;
    logic [15:0]   w;
    v = '0;
    for (int k = 0; k < NL; k++) begin
      if (mode == 0) v[k] = strm[k][pos + ui];
      else if (mode == 1) begin
        w = {4'hA, 8'(k), 4'hA};
        v[k] = w[ui % 16];
      end
    end
`ifdef PATTERN_GEN_ERR_INJECT_EN
    if (ui == 0 && mode != 2) v = v ^ err_lanes;
`endif
    return v;
  endfunction

  // Called at the negedge on which the request was driven.
  task automatic expect_burst(input int mode, input string name, output logic [7:0] first8);
    logic [NL-1:0] e;
    int bad;
    bad = 0;
    first8 = '0;
    @(negedge clk);
    n_chk++;
    if (den !== 1'b0 || lane !== '0) $display("FAIL %s_latency den=%b lane=%h want den=0 lane=0", name, den, lane);
    else n_pass++;
    for (int ui = 0; ui < PUI; ui++) begin
      @(negedge clk);
      e = exp_lanes(mode, ui);
      if (ui < 8) first8[ui] = lane[0];
      n_chk++;
      if (den !== 1'b1 || lane !== e || valid !== ((ui % 8) < 4) || fin !== 1'b0) begin
        bad++;
        if (bad <= 4)
          $display("FAIL %s_ui%0d den=%b lane=%h valid=%b fin=%b want den=1 lane=%h valid=%b fin=0",
                   name, ui, den, lane, valid, fin, e, ((ui % 8) < 4));
      end else n_pass++;
    end
    @(negedge clk);
    n_chk++;
    if (den !== 1'b0 || lane !== '0 || valid !== 1'b0 || fin !== 1'b1)
      $display("FAIL %s_end den=%b lane=%h valid=%b fin=%b want 0/0/0/1", name, den, lane, valid, fin);
    else n_pass++;
    if (mode == 0) pos += PUI;
  endtask

  task automatic finish_hold(input string name);
    int h;
    h = $urandom_range(1, 4);
    repeat (h) begin
      @(negedge clk);
      n_chk++;
      if (fin !== 1'b1 || den !== 1'b0) $display("FAIL %s_hold fin=%b den=%b want 1/0", name, fin, den);
      else n_pass++;
    end
    cw = 2'b00; val_en = 1'b0;
    @(negedge clk);
    n_chk++;
    if (fin !== 1'b0 || den !== 1'b0) $display("FAIL %s_release fin=%b den=%b want 0/0", name, fin, den);
    else n_pass++;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    n_chk++;
    if (lane !== '0 || valid !== 1'b0 || den !== 1'b0 || fin !== 1'b0)
      $display("FAIL reset lane=%h valid=%b den=%b fin=%b want all 0", lane, valid, den, fin);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (lane !== '0 || den !== 1'b0 || fin !== 1'b0)
      $display("FAIL reset_idle lane=%h den=%b fin=%b want 0", lane, den, fin);
    else n_pass++;
  endtask

  task automatic test_lfsr_burst();
    logic [7:0] f8;
    cw = 2'b10;
    expect_burst(0, "lfsr1", f8);
    n_chk++;
    if (f8 !== 8'b1101_1100) $display("FAIL lfsr1_lane0_first8 got=%b want=11011100 (UI7..UI0)", f8);
    else n_pass++;
    finish_hold("lfsr1");
  endtask

  task automatic test_lfsr_continue();
    logic [7:0] f8;
    repeat ($urandom_range(1, 6)) @(negedge clk);
    cw = 2'b10;
    expect_burst(0, "lfsr_cont", f8);
    finish_hold("lfsr_cont");
  endtask

  task automatic test_clear();
    logic [7:0] f8;
    int h;
    h = $urandom_range(1, 3);
    cw = 2'b01;
    repeat (h) begin
      @(negedge clk);
      n_chk++;
      if (den !== 1'b0 || fin !== 1'b0 || lane !== '0) $display("FAIL clear_idle den=%b fin=%b lane=%h want 0", den, fin, lane);
      else n_pass++;
    end
    pos = 0;
    cw = 2'b10;
    expect_burst(0, "lfsr_clr", f8);
    n_chk++;
    if (f8 !== 8'b1101_1100) $display("FAIL clr_lane0_first8 got=%b want=11011100", f8);
    else n_pass++;
    finish_hold("lfsr_clr");
  endtask

  task automatic test_id_burst();
    logic [7:0] f8;
    cw = 2'b11;
    expect_burst(1, "id", f8);
    finish_hold("id");
  endtask

  task automatic test_val_burst();
    logic [7:0] f8;
    val_en = 1'b1;
    expect_burst(2, "val", f8);
    finish_hold("val");
  endtask

  task automatic test_cw_wins();
    logic [7:0] f8;
    cw = 2'b10; val_en = 1'b1;
    expect_burst(0, "cw_wins", f8);
    finish_hold("cw_wins");
  endtask

  task automatic test_abort();
    int stop;
    logic [NL-1:0] e;
    for (int pass = 0; pass < 2; pass++) begin
      stop = (pass == 0) ? 100 : $urandom_range(5, 40);
      cw = 2'b10;
      @(negedge clk);
      for (int ui = 0; ui < stop; ui++) begin
        @(negedge clk);
        e = exp_lanes(0, ui);
        n_chk++;
        if (den !== 1'b1 || lane !== e) $display("FAIL abort_ui%0d den=%b lane=%h want 1 %h", ui, den, lane, e);
        else n_pass++;
      end
      cw = 2'b00;
      @(negedge clk);
      n_chk++;
      if (den !== 1'b0 || lane !== '0 || valid !== 1'b0 || fin !== 1'b0)
        $display("FAIL abort_out den=%b lane=%h valid=%b fin=%b want all 0", den, lane, valid, fin);
      else n_pass++;
      pos += stop;
      repeat (5) begin
        @(negedge clk);
        n_chk++;
        if (fin !== 1'b0 || den !== 1'b0) $display("FAIL abort_idle fin=%b den=%b want 0", fin, den);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int r;
    logic [NL-1:0] e;
    r = $urandom_range(10, 200);
    cw = 2'b11;
    @(negedge clk);
    repeat (r) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (lane !== '0 || valid !== 1'b0 || den !== 1'b0 || fin !== 1'b0)
      $display("FAIL reset_mid lane=%h valid=%b den=%b fin=%b want all 0", lane, valid, den, fin);
    else n_pass++;
    @(negedge clk);
    cw = 2'b00;
    rst_n = 1'b1;
    pos = 0;
    @(negedge clk);
    cw = 2'b10;
    @(negedge clk);
    for (int ui = 0; ui < 30; ui++) begin
      @(negedge clk);
      e = exp_lanes(0, ui);
      n_chk++;
      if (den !== 1'b1 || lane !== e) $display("FAIL reseed_ui%0d den=%b lane=%h want 1 %h", ui, den, lane, e);
      else n_pass++;
    end
    cw = 2'b00;
    pos += 30;
    @(negedge clk);
    n_chk++;
    if (den !== 1'b0 || fin !== 1'b0) $display("FAIL reseed_abort den=%b fin=%b want 0", den, fin);
    else n_pass++;
  endtask

`ifdef PATTERN_GEN_ERR_INJECT_EN
  task automatic test_err_inject();
    logic [7:0] f8;
    err_lanes = NL'($urandom()) | NL'(1);
    cw = 2'b10;
    expect_burst(0, "err_inj", f8);
    n_chk++;
    if (f8[0] !== ~strm[0][pos - PUI]) $display("FAIL err_inj_lane0_ui0 got=%b want=%b", f8[0], ~strm[0][pos - PUI]);
    else n_pass++;
    finish_hold("err_inj");
    err_lanes = '0;
  endtask
`endif

  initial begin
    build_model();
    test_reset();
    test_lfsr_burst();
    test_lfsr_continue();
    test_clear();
    test_id_burst();
    test_val_burst();
    test_cw_wins();
    test_abort();
    test_reset_mid();
`ifdef PATTERN_GEN_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mb_point_test_pattern_gen.md
Name: mb_point_test_pattern_gen

Overview:
- Mainband/valid-lane pattern generator that sits directly downstream of the TX-initiated D2C point-test controller.
- Consumes that controller's pattern-generator control word and valtrain enable.
- Drives one UI per clock onto NUM_LANES data lanes and the valid lane.
- Returns a pattern-finished level when the programmed burst length has been sent.

Parameters:
- NUM_LANES, 16, number of mainband data lanes.
- PATTERN_UI, 4096, UIs per burst; must be ≥16 and a multiple of 16.
- SEED_BASE, 23'h1DBFBC, LFSR base seed. Lane k seed = SEED_BASE ^ (k << 4), never zero.

Ports:
- clk  input  1  block clock; one UI per cycle.
- rst_n  input  1  asynchronous active-low reset.
- i_mainband_pattern_generator_cw  input  2  control word: 00 idle, 01 clear LFSRs, 10 LFSR burst, 11 per-lane ID burst.
- i_val_pattern_en  input  1  request a valtrain burst; honoured only when cw=00.
- o_lane_data  output  NUM_LANES  one bit per lane per UI.
- o_valid_lane  output  1  valid-lane bit.
- o_data_en  output  1  high on every cycle that carries burst data.
- o_pattern_finished  output  1  level; burst complete.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, UI counter 0, every LFSR loaded with its lane seed.
- FSM states: IDLE, RUN_LFSR, RUN_ID, RUN_VAL, DONE.
- IDLE transitions:
  - cw=10 → RUN_LFSR.
  - cw=11 → RUN_ID.
  - cw=00 with val_en=1 → RUN_VAL.
  - cw=01: reload all LFSRs with their seeds on every cycle it is held; stay in IDLE; no data; finished stays 0.
  - cw≠00 together with val_en=1: cw wins.
- Latency: request sampled at edge N; first data UI visible after edge N+1. o_data_en is high for exactly PATTERN_UI consecutive cycles.
- UI counter: width $clog2(PATTERN_UI+1); cleared on entry to any RUN state. After the last UI the FSM goes to DONE.
- DONE: o_data_en=0, lanes=0, valid=0, o_pattern_finished=1. The FSM holds DONE until the request that started the burst drops (cw→00 for mainband runs, val_en→0 for RUN_VAL), then returns to IDLE with finished=0 on the next edge.
- Abort: if the starting request drops or changes during a RUN state, the FSM returns to IDLE on the next edge. Outputs go to 0 and finished is not asserted. A new request is honoured only from IDLE.
- LFSR (per lane, Fibonacci, x^23+x^21+x^18+x^15+x^7+x^2+1):
  - output bit = lfsr[22].
  - next = {lfsr[21:0], lfsr[22]^lfsr[20]^lfsr[17]^lfsr[14]^lfsr[6]^lfsr[1]}.
  - Advances only on cycles where RUN_LFSR drives data.
  - State persists across bursts unless cleared by cw=01 or by reset.
- Per-lane ID: lane k repeats the 16-bit word {4'b1010, k[7:0], 4'b1010}, LSB first. Phase comes from UI counter[3:0].
- Valid lane:
  - During RUN_LFSR, RUN_ID and RUN_VAL: repeating 1111_0000 (4 UI high, 4 UI low), phase from counter[2:0].
  - In RUN_VAL, o_lane_data = 0.
- Reset asserted mid-burst: immediate return to reset values. LFSRs are reseeded.

Optional Feature:
- Macro: PATTERN_GEN_ERR_INJECT_EN.
- Defined: adds input i_err_inject_lanes[NUM_LANES-1:0], sampled at burst start. For each selected lane, the data bit of the first UI of every RUN_LFSR/RUN_ID burst is inverted; LFSR state is unaffected. Used to exercise the downstream comparators.
- Undefined: the port does not exist and data is never altered.

Test Plan:
- Reset, then cw=10 → lane0 first 8 UIs 0,0,1,1,1,0,1,1; o_data_en high exactly 4096 cycles; then o_pattern_finished=1 until cw=00, then 0 one edge later.
- cw=11 → lane5 UIs 0–15 = 0,1,0,1,1,0,1,0,0,0,0,0,0,1,0,1, repeating every 16 UI. o_valid_lane = 1,1,1,1,0,0,0,0 repeating.
- cw=00 with val_en=1 → o_lane_data=0, valid 11110000×512, finished after 4096 UI. cw=10 with val_en=1 → LFSR burst runs, val_en ignored.
- LFSR burst, cw=00, second cw=10 → lane0 continues the sequence (UI 4096 onward). Insert cw=01 for 1 cycle before the second burst → lane0 restarts 0,0,1,1,1,0,1,1.
- Drop cw to 00 at UI 100 → outputs 0 next edge, finished never asserted, FSM returns to IDLE. Assert rst_n=0 mid-burst → all outputs 0 asynchronously.
- With PATTERN_GEN_ERR_INJECT_EN and i_err_inject_lanes=16'h0001, cw=10 → lane0 UI0 = 1 (inverted); UI1 onward match the reference sequence.
